// File: rtl/booth_arb_pkg.sv
// Shared state encoding, ID-width helper and default sizing for booth_mult_arbiter.
package booth_arb_pkg;

    localparam int BOOTH_ARB_WIDTH   = 32;
    localparam int BOOTH_ARB_NUM_REQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    // Requester index width; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr, with wrap-around.
module rr_arbiter
    import booth_arb_pkg::*;
#(
    parameter int NUM_REQ = BOOTH_ARB_NUM_REQ,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_vld
);

    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_vld = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_vld && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                grant_vld                               = 1'b1;
                grant[(int'(rr_ptr) + k) % NUM_REQ]     = 1'b1;
                grant_id                                = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/booth_mult_arbiter.sv
// Round-robin front end sharing one sequential Booth multiplier among NUM_REQ requesters.
// Optional BOOTH_ARB_ZERO_BYPASS_EN: zero-operand requests skip the core and respond one cycle after accept.
module booth_mult_arbiter
    import booth_arb_pkg::*;
#(
    parameter int  WIDTH   = BOOTH_ARB_WIDTH,
    parameter int  NUM_REQ = BOOTH_ARB_NUM_REQ,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_m,
    input  logic [NUM_REQ*WIDTH-1:0] req_q,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]       rsp_p,
    output logic                     mul_start,
    output logic [WIDTH-1:0]         mul_m,
    output logic [WIDTH-1:0]         mul_q,
    input  logic                     mul_done,
    input  logic [2*WIDTH-1:0]       mul_p,
    output logic                     busy
);

    arb_state_t           r_state;
    arb_state_t           w_next;
    logic [ID_W-1:0]      r_rr_ptr;
    logic [ID_W-1:0]      r_id;
    logic [WIDTH-1:0]     r_m;
    logic [WIDTH-1:0]     r_q;
    logic [2*WIDTH-1:0]   r_p;
    logic [NUM_REQ-1:0]   w_gnt;
    logic [ID_W-1:0]      w_gnt_id;
    logic                 w_gnt_vld;
    logic                 w_accept;
    logic                 w_zero;
    logic [WIDTH-1:0]     w_sel_m;
    logic [WIDTH-1:0]     w_sel_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req_valid (req_valid),
        .rr_ptr    (r_rr_ptr),
        .grant     (w_gnt),
        .grant_id  (w_gnt_id),
        .grant_vld (w_gnt_vld)
    );

    assign w_sel_m  = req_m[int'(w_gnt_id)*WIDTH +: WIDTH];
    assign w_sel_q  = req_q[int'(w_gnt_id)*WIDTH +: WIDTH];
    assign w_accept = (r_state == ST_IDLE) && w_gnt_vld;

`ifdef BOOTH_ARB_ZERO_BYPASS_EN
    assign w_zero = (w_sel_m == '0) || (w_sel_q == '0);
`else
    assign w_zero = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        mul_start = 1'b0;
        rsp_valid = 1'b0;
        busy      = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                req_ready = w_gnt;
                if (w_accept) begin
                    w_next = w_zero ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mul_start = 1'b1;
                w_next    = ST_WAIT;
            end
            ST_WAIT: begin
                if (mul_done) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Operands are captured at accept so the core sees stable values until done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_id     <= '0;
            r_m      <= '0;
            r_q      <= '0;
            r_p      <= '0;
        end else begin
            if (w_accept) begin
                r_m  <= w_sel_m;
                r_q  <= w_sel_q;
                r_id <= w_gnt_id;
                if (w_zero) begin
                    r_p <= '0;
                end
            end
            if ((r_state == ST_WAIT) && mul_done) begin
                r_p <= mul_p;
            end
            if ((r_state == ST_RESP) && rsp_ready) begin
                r_rr_ptr <= (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + ID_W'(1);
            end
        end
    end

    assign rsp_id = r_id;
    assign rsp_p  = r_p;
    assign mul_m  = r_m;
    assign mul_q  = r_q;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed bench for booth_mult_arbiter with a 32-cycle stub multiplier core.
module tb_booth_mult_arbiter;
    import booth_arb_pkg::*;

    localparam int W   = 32;
    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int L   = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_m;
    logic [N*W-1:0]   req_q;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IDW-1:0]   rsp_id;
    logic [2*W-1:0]   rsp_p;
    logic             mul_start;
    logic [W-1:0]     mul_m;
    logic [W-1:0]     mul_q;
    logic             mul_done;
    logic [2*W-1:0]   mul_p;
    logic             busy;

    logic                  stub_done = 1'b0;
    logic signed [2*W-1:0] stub_p    = '0;
    logic                  stub_run  = 1'b0;
    int                    stub_cnt  = 0;
    logic                  inj_done;
    logic [2*W-1:0]        inj_p;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    booth_mult_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_m     (req_m),
        .req_q     (req_q),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .mul_start (mul_start),
        .mul_m     (mul_m),
        .mul_q     (mul_q),
        .mul_done  (mul_done),
        .mul_p     (mul_p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stub core: done is high L cycles after the start cycle; it ignores rst on purpose.
    always @(posedge clk) begin
        stub_done <= 1'b0;
        if (mul_start) begin
            stub_run <= 1'b1;
            stub_cnt <= 1;
        end else if (stub_run) begin
            if (stub_cnt == L - 1) begin
                stub_done <= 1'b1;
                stub_p    <= $signed(mul_m) * $signed(mul_q);
                stub_run  <= 1'b0;
            end
            stub_cnt <= stub_cnt + 1;
        end
    end

    assign mul_done = stub_done | inj_done;
    assign mul_p    = inj_done ? inj_p : stub_p;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one request, returns handshake-to-start and handshake-to-response distances.
    task automatic run_txn(input int id, input logic [W-1:0] m, input logic [W-1:0] q,
                           output int lat, output int st_lat, output int nstart);
        int h;
        h      = -1;
        lat    = -1;
        st_lat = -1;
        nstart = 0;
        req_m[id*W +: W] = m;
        req_q[id*W +: W] = q;
        req_valid[id]    = 1'b1;
        #1;
        for (int i = 0; i < 50; i++) begin
            if (req_ready[id]) begin
                h = cyc;
                break;
            end
            step();
        end
        if (h < 0) begin
            req_valid[id] = 1'b0;
            return;
        end
        step();
        req_valid[id] = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (mul_start) begin
                if (nstart == 0) st_lat = cyc - h;
                nstart++;
            end
            if (rsp_valid) begin
                lat = cyc - h;
                break;
            end
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, st_lat, nstart, found;
        int exp_id [5];
        int exp_p  [5];
        rst       = 1'b1;
        req_valid = '0;
        req_m     = '0;
        req_q     = '0;
        rsp_ready = 1'b1;
        inj_done  = 1'b0;
        inj_p     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id",    rsp_id,    0);
        chk("rst_rsp_p",     rsp_p,     0);
        chk("rst_mul_start", mul_start, 0);
        chk("rst_mul_m",     mul_m,     0);
        chk("rst_mul_q",     mul_q,     0);
        chk("rst_busy",      busy,      0);
        rst = 1'b0;
        step();

        // Single request: 10 x -150
        run_txn(0, 32'd10, -150, lat, st_lat, nstart);
        chk("t1_start_lat", st_lat, 1);
        chk("t1_nstart",    nstart, 1);
        chk("t1_rsp_lat",   lat,    34);
        chk("t1_rsp_p",     rsp_p,  -1500);
        chk("t1_rsp_id",    rsp_id, 0);
        step();
        chk("t1_drained",   rsp_valid, 0);
        chk("t1_idle",      busy,      0);

        // All four held valid: grant order 0,1,2,3,0 from rr_ptr=0
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        req_m[0*W +: W] = 32'd10;  req_q[0*W +: W] = 32'd10;
        req_m[1*W +: W] = -10;     req_q[1*W +: W] = -150;
        req_m[2*W +: W] = -150;    req_q[2*W +: W] = 32'd150;
        req_m[3*W +: W] = 32'd10;  req_q[3*W +: W] = 32'd22;
        exp_id = '{0, 1, 2, 3, 0};
        exp_p  = '{100, 1500, -22500, 220, 100};
        req_valid = '1;
        #1;
        for (int k = 0; k < 5; k++) begin
            found = 0;
            for (int i = 0; i < 20; i++) begin
                if (req_ready != '0) begin
                    found = 1;
                    break;
                end
                step();
            end
            chk("t2_grant", req_ready, 64'(1) << exp_id[k]);
            step();
            found = 0;
            for (int i = 0; i < 60; i++) begin
                if (rsp_valid) begin
                    found = 1;
                    break;
                end
                step();
            end
            chk("t2_rsp_seen", found,  1);
            chk("t2_rsp_id",   rsp_id, exp_id[k]);
            chk("t2_rsp_p",    rsp_p,  exp_p[k]);
            if (k == 4) req_valid = '0;
            step();
        end

        // Back-pressure for 20 cycles with a spurious done in RESP; rr_ptr is 1
        rsp_ready       = 1'b0;
        req_m[2*W +: W] = 32'd3;
        req_q[2*W +: W] = 32'd3;
        req_valid[2]    = 1'b1;
        run_txn(1, -7, 32'd9, lat, st_lat, nstart);
        chk("t3_rsp_lat", lat,   34);
        chk("t3_mul_m",   mul_m, 64'h0000_0000_FFFF_FFF9);
        chk("t3_mul_q",   mul_q, 9);
        for (int i = 0; i < 20; i++) begin
            chk("t3_hold_valid", rsp_valid, 1);
            chk("t3_hold_p",     rsp_p,     -63);
            chk("t3_hold_id",    rsp_id,    1);
            chk("t3_no_ready",   req_ready, 0);
            if (i == 10) begin
                inj_done = 1'b1;
                inj_p    = 64'h0000_0000_0000_1234;
            end
            step();
            inj_done = 1'b0;
        end
        rsp_ready = 1'b1;
        step();
        chk("t3_accepted",  rsp_valid, 0);
        chk("t3_next_gnt",  req_ready, 4'b0100);
        req_valid[2] = 1'b0;
        #1;
        chk("t3_skip",      req_ready, 0);

        // Spurious done while idle
        inj_done = 1'b1;
        inj_p    = 64'h0000_0000_0000_5555;
        step();
        inj_done = 1'b0;
        chk("t6_idle_busy",  busy,      0);
        chk("t6_idle_valid", rsp_valid, 0);
        chk("t6_idle_p",     rsp_p,     -63);
        chk("t6_idle_start", mul_start, 0);

        // Reset 10 cycles into WAIT, stale done afterwards
        req_m[3*W +: W] = 32'd5;
        req_q[3*W +: W] = 32'd5;
        req_valid[3]    = 1'b1;
        #1;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready[3]) begin
                found = 1;
                break;
            end
            step();
        end
        chk("t4_grant", found, 1);
        step();
        req_valid[3] = 1'b0;
        chk("t4_start", mul_start, 1);
        step();
        repeat (10) step();
        chk("t4_in_wait", busy, 1);
        rst = 1'b1;
        #1;
        chk("t4_rst_req_ready", req_ready, 0);
        chk("t4_rst_rsp_valid", rsp_valid, 0);
        chk("t4_rst_rsp_id",    rsp_id,    0);
        chk("t4_rst_rsp_p",     rsp_p,     0);
        chk("t4_rst_mul_start", mul_start, 0);
        chk("t4_rst_mul_m",     mul_m,     0);
        chk("t4_rst_mul_q",     mul_q,     0);
        chk("t4_rst_busy",      busy,      0);
        step();
        step();
        rst = 1'b0;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            if (stub_done) begin
                found = 1;
                break;
            end
            step();
        end
        chk("t4_stale_done_seen", found, 1);
        step();
        chk("t4_stale_busy",  busy,      0);
        chk("t4_stale_valid", rsp_valid, 0);
        chk("t4_stale_p",     rsp_p,     0);
        run_txn(2, 32'd10, 32'd4, lat, st_lat, nstart);
        chk("t4_rsp_lat", lat,    34);
        chk("t4_rsp_p",   rsp_p,  40);
        chk("t4_rsp_id",  rsp_id, 2);
        step();

        // Zero operand
        run_txn(0, 32'd0, 32'd150, lat, st_lat, nstart);
`ifdef BOOTH_ARB_ZERO_BYPASS_EN
        chk("t5_rsp_lat", lat,    1);
        chk("t5_nstart",  nstart, 0);
`else
        chk("t5_rsp_lat", lat,    34);
        chk("t5_nstart",  nstart, 1);
`endif
        chk("t5_rsp_p",   rsp_p,  0);
        chk("t5_rsp_id",  rsp_id, 0);
        step();
        chk("t5_drained", rsp_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_mult_arbiter.md
# booth_mult_arbiter

Round-robin scheduler that shares a single sequential Booth multiplier core among `NUM_REQ` requesters. It accepts signed operand pairs over per-requester valid/ready handshakes and sequences the core through start/done. It returns each 2·WIDTH-bit signed product, tagged with the requester ID, over a single valid/ready response channel. It sits between the arithmetic clients and the Booth multiplier datapath.

## Interface
- `WIDTH`, 32: operand width; product is 2·WIDTH.
- `NUM_REQ`, 4: number of requesters (2..16).
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester request.
- `req_ready`  out  NUM_REQ  one-hot grant/accept.
- `req_m`  in  NUM_REQ·WIDTH  flattened signed multiplicands; slot i = bits [i·WIDTH +: WIDTH].
- `req_q`  in  NUM_REQ·WIDTH  flattened signed multipliers.
- `rsp_valid`  out  1  product available.
- `rsp_ready`  in  1  consumer accepts product.
- `rsp_id`  out  clog2(NUM_REQ)  requester index of product.
- `rsp_p`  out  2·WIDTH  signed product.
- `mul_start`  out  1  one-cycle start pulse to core.
- `mul_m`, `mul_q`  out  WIDTH each  operands to core; stable from start until done.
- `mul_done`  in  1  core completion pulse.
- `mul_p`  in  2·WIDTH  core product; valid when `mul_done`=1.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: the winner is the first asserted `req_valid` at or after `rr_ptr`, searching with wrap-around. `req_ready[winner]`=1 combinationally, and only while in IDLE. On handshake the block latches the operands and the ID, then goes to ISSUE. No request → stays in IDLE.
- ISSUE: `mul_start`=1 for exactly one cycle; next state WAIT.
- WAIT: on `mul_done`, latch `mul_p` into `rsp_p`; next state RESP.
- RESP: hold `rsp_valid`=1 with `rsp_id`/`rsp_p` stable until `rsp_ready`. On the accepting edge: go to IDLE and set `rr_ptr` = (id+1) mod NUM_REQ.
- `mul_done` outside WAIT is ignored.
- `mul_m`/`mul_q` hold the latched operands from ISSUE through RESP. They are not muxed live from the request inputs.
- Arithmetic: operands are two's-complement. The product passes through unmodified; no truncation or saturation.
- A requester that deasserts `req_valid` before being granted is simply skipped; no penalty.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_p`=0, `mul_start`=0, `mul_m`=0, `mul_q`=0, `busy`=0, `rr_ptr`=0, state IDLE.
- `rst` asserted mid-operation aborts immediately. Any in-flight product is discarded, and a later `mul_done` from the core is ignored.
- Accept (edge k) → `mul_start` at cycle k+1 → WAIT from cycle k+2.
- `rsp_valid` rises the cycle after `mul_done`. Total latency is L+2 cycles, where L = core cycles from start to done.
- One request is in flight at a time; throughput is one product per L+3 cycles when `rsp_ready` is held high.
- `rsp_valid` never drops without `rsp_ready`. Back-pressure in RESP stalls all requesters.

## Configuration
- `BOOTH_ARB_ZERO_BYPASS_EN` defined: at accept, if either operand is 0, the FSM skips ISSUE/WAIT and goes directly to RESP with `rsp_p`=0. `mul_start` is never pulsed for that request, and latency is 1 cycle.
- Not defined: every request goes through the core.

## Structure
- Package `booth_arb_pkg` holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - the ID-width function/localparam;
  - default WIDTH/NUM_REQ constants.
- Sub-module `rr_arbiter`:
  - purely combinational;
  - inputs `req_valid` and `rr_ptr`;
  - outputs a one-hot grant and its encoded index.
- The FSM and registers live in the top.

## Test plan
Bench uses a stub core with L=32 that returns M·Q.
- Single requester 0, M=10, Q=−150, `rsp_ready`=1 → `mul_start` pulses 1 cycle after accept; `rsp_valid` 34 cycles after accept with `rsp_p`=−1500, `rsp_id`=0.
- All 4 requesters held valid with distinct operands (10×10, −10×−150, −150×150, 10×22) → grants in order 0,1,2,3,0. Products are 100, 1500, −22500, 220 with matching IDs.
- `rsp_ready` held low 20 cycles in RESP → `rsp_valid`, `rsp_id`, `rsp_p` stable; no `req_ready` asserted; accepted on the first `rsp_ready` cycle.
- `rst` pulsed 10 cycles into WAIT, stub `mul_done` arrives later → all outputs at reset values; stale done ignored; next request 10×4 → 40, `rsp_id` correct.
- M=0, Q=150 → with `BOOTH_ARB_ZERO_BYPASS_EN`: `rsp_p`=0 one cycle after accept, no `mul_start`. Without the macro: `rsp_p`=0 after 34 cycles.
- Spurious `mul_done` in IDLE and in RESP → no state change; `rsp_p` unchanged.
